// File: rtl/uart_rx_to_between_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive front end feeding Between_to_FIFO.
//   - rx_state_t : receive FSM encodings (3-bit)
//   - hs_state_t : downstream four-phase handshake FSM encodings (2-bit)
//   - BYTE_W     : width of one UART data byte
//   - half_bit_last() : counter terminal value for the mid-start-bit check
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_STOP  = 3'd3,
        R_BREAK = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_SENT = 2'd1,
        H_DROP = 2'd2
    } hs_state_t;

    // The start bit is re-checked half a bit after the falling edge so that
    // every later sample lands near the centre of its bit cell. The counter
    // starts at zero, hence the -1.
    function automatic int half_bit_last(input int clks_per_bit);
        return (clks_per_bit / 2) - 1;
    endfunction

endpackage

// File: rtl/uart_rx_to_between_if.sv
// -----------------------------------------------------------------------------
// uart_rx_to_between_if
// Byte delivery bus between the UART receiver and the Between_to_FIFO stage.
//   t0..t7   : byte bits, t0 = byte[7] (MSB) ... t7 = byte[0] (LSB)
//   tsent    : request / byte valid, driven by the receiver
//   trecieve : acknowledge, driven by the downstream stage
// Four-phase protocol: tsent rises, trecieve rises, tsent falls, trecieve
// falls. t0..t7 stay stable from tsent rising until the sender is idle again.
// -----------------------------------------------------------------------------
interface uart_rx_to_between_if;

    logic t0;
    logic t1;
    logic t2;
    logic t3;
    logic t4;
    logic t5;
    logic t6;
    logic t7;
    logic tsent;
    logic trecieve;

    // Receiver side: drives the byte and the request.
    modport master (
        output t0, t1, t2, t3, t4, t5, t6, t7,
        output tsent,
        input  trecieve
    );

    // Downstream side: consumes the byte and acknowledges.
    modport slave (
        input  t0, t1, t2, t3, t4, t5, t6, t7,
        input  tsent,
        output trecieve
    );

endinterface

// File: rtl/uart_rx_to_between_rx_sync.sv
// -----------------------------------------------------------------------------
// rx_sync
// Two-flop synchroniser for asynchronous inputs. Both stages reset to RST_VAL
// so that an idle-high line such as a UART rx does not look like a start bit
// while reset is being released.
//   clk   : destination clock
//   reset : asynchronous, active-low
//   d     : asynchronous input(s)
//   q     : synchronised output, two clk cycles behind d
// -----------------------------------------------------------------------------
module rx_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx_to_between.sv
// -----------------------------------------------------------------------------
// uart_rx_to_between
// 8N1 UART receiver that hands each received byte to the Between_to_FIFO stage
// over a tsent/trecieve four-phase handshake. A one-byte holding register sits
// between the receiver and the output register so that one complete frame can
// arrive while the previous byte is still being acknowledged.
//
// Ports
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-low
//   rx          : UART serial line, asynchronous, idle high
//   enable      : receive enable; low forces the receiver to idle
//   clear_err   : synchronous clear of the sticky error flags
//   bus         : byte/handshake bus (master side: t0..t7, tsent; trecieve in)
//   framing_err : sticky, stop bit sampled low
//   overrun_err : sticky, a completed byte was dropped (holding register full)
//   busy        : receive FSM is not idle
//   byte_count  : bytes acknowledged downstream, wraps 255 -> 0
// -----------------------------------------------------------------------------
module uart_rx_to_between
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  enable,
    input  logic                  clear_err,
    uart_rx_to_between_if.master  bus,
    output logic                  framing_err,
    output logic                  overrun_err,
    output logic                  busy,
    output logic [7:0]            byte_count
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_last(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    // -------------------------------------------------------------------------
    // rx synchroniser; everything below sees only rx_s.
    // -------------------------------------------------------------------------
    logic rx_s;

    rx_sync #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // -------------------------------------------------------------------------
    // Receive FSM
    // -------------------------------------------------------------------------
    rx_state_t         rx_state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        bit_idx_reg;
    logic [BYTE_W-1:0] shreg_reg;

    logic bit_end;
    logic stop_ok;
    logic stop_bad;

    assign bit_end  = (cnt_reg == BIT_LAST);
    // Stop-bit sample cycle outcomes. Gated by enable because dropping enable
    // aborts the frame without pushing a byte or flagging an error.
    assign stop_ok  = enable && (rx_state_reg == R_STOP) && bit_end &&  rx_s;
    assign stop_bad = enable && (rx_state_reg == R_STOP) && bit_end && !rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_reg <= R_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shreg_reg    <= '0;
        end else if (!enable) begin
            rx_state_reg <= R_IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
        end else begin
            case (rx_state_reg)
                R_IDLE: begin
                    if (!rx_s) begin
                        rx_state_reg <= R_START;
                        cnt_reg      <= '0;
                    end
                end

                R_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        // Line back high at mid start bit: it was a glitch.
                        rx_state_reg <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                R_DATA: begin
                    if (bit_end) begin
                        cnt_reg                <= '0;
                        shreg_reg[bit_idx_reg] <= rx_s;
                        if (bit_idx_reg == 3'd7) begin
                            rx_state_reg <= R_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                R_STOP: begin
                    if (bit_end) begin
                        cnt_reg      <= '0;
                        rx_state_reg <= rx_s ? R_IDLE : R_BREAK;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                // A line held low (break) must return high before the next
                // falling edge can be taken as a start bit.
                R_BREAK: begin
                    if (rx_s) begin
                        rx_state_reg <= R_IDLE;
                    end
                end

                default: begin
                    rx_state_reg <= R_IDLE;
                    cnt_reg      <= '0;
                end
            endcase
        end
    end

    assign busy = (rx_state_reg != R_IDLE);

    // -------------------------------------------------------------------------
    // Holding register
    // -------------------------------------------------------------------------
    hs_state_t         hs_state_reg;
    logic [BYTE_W-1:0] hold_reg;
    logic              hold_valid_reg;

    logic pop;
    logic push_accept;
    logic overrun_set;

    // The handshake FSM takes the held byte whenever it is idle.
    assign pop         = (hs_state_reg == H_IDLE) && hold_valid_reg;
    // A same-cycle pop frees the slot, so the new byte can be accepted.
    assign push_accept = stop_ok && (!hold_valid_reg || pop);
    assign overrun_set = stop_ok &&  hold_valid_reg && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
        end else if (push_accept) begin
            hold_reg       <= shreg_reg;
            hold_valid_reg <= 1'b1;
        end else if (pop) begin
            hold_valid_reg <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Handshake FSM (independent of enable so an outstanding byte completes)
    // -------------------------------------------------------------------------
    logic [BYTE_W-1:0] out_reg;
    logic              tsent_reg;
    logic [7:0]        byte_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_state_reg   <= H_IDLE;
            out_reg        <= '0;
            tsent_reg      <= 1'b0;
            byte_count_reg <= '0;
        end else begin
            case (hs_state_reg)
                H_IDLE: begin
                    if (hold_valid_reg) begin
                        out_reg      <= hold_reg;
                        tsent_reg    <= 1'b1;
                        hs_state_reg <= H_SENT;
                    end
                end

                H_SENT: begin
                    if (bus.trecieve) begin
                        tsent_reg      <= 1'b0;
                        byte_count_reg <= byte_count_reg + 8'd1;
                        hs_state_reg   <= H_DROP;
                    end
                end

                // Wait for the acknowledge to fall before offering the next
                // byte; out_reg is held untouched until then.
                H_DROP: begin
                    if (!bus.trecieve) begin
                        hs_state_reg <= H_IDLE;
                    end
                end

                default: begin
                    hs_state_reg <= H_IDLE;
                    tsent_reg    <= 1'b0;
                end
            endcase
        end
    end

    // t0 carries the MSB, t7 the LSB.
    assign bus.t0    = out_reg[7];
    assign bus.t1    = out_reg[6];
    assign bus.t2    = out_reg[5];
    assign bus.t3    = out_reg[4];
    assign bus.t4    = out_reg[3];
    assign bus.t5    = out_reg[2];
    assign bus.t6    = out_reg[1];
    assign bus.t7    = out_reg[0];
    assign bus.tsent = tsent_reg;

    assign byte_count = byte_count_reg;

    // -------------------------------------------------------------------------
    // Sticky error flags; a set in the same cycle as clear_err wins.
    // -------------------------------------------------------------------------
    logic framing_err_reg;
    logic overrun_err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            framing_err_reg <= 1'b0;
            overrun_err_reg <= 1'b0;
        end else begin
            if (stop_bad) begin
                framing_err_reg <= 1'b1;
            end else if (clear_err) begin
                framing_err_reg <= 1'b0;
            end

            if (overrun_set) begin
                overrun_err_reg <= 1'b1;
            end else if (clear_err) begin
                overrun_err_reg <= 1'b0;
            end
        end
    end

    assign framing_err = framing_err_reg;
    assign overrun_err = overrun_err_reg;

endmodule

// File: tb/tb_uart_rx_to_between.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_to_between
// Directed bench for uart_rx_to_between with CLKS_PER_BIT = 8. Frames are
// driven on rx at falling clock edges, outputs are sampled at falling edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_to_between;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       enable;
    logic       clear_err;
    logic       framing_err;
    logic       overrun_err;
    logic       busy;
    logic [7:0] byte_count;

    int total = 0;
    int bad   = 0;
    int exp_count = 0;

    uart_rx_to_between_if bus_if ();

    uart_rx_to_between #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .enable      (enable),
        .clear_err   (clear_err),
        .bus         (bus_if),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .busy        (busy),
        .byte_count  (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    function automatic logic [7:0] t_byte();
        return {bus_if.t0, bus_if.t1, bus_if.t2, bus_if.t3,
                bus_if.t4, bus_if.t5, bus_if.t6, bus_if.t7};
    endfunction

    // One 8N1 frame, CPB clocks per bit, LSB first; rx is left at stop_val.
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        @(negedge clk); rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); rx = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk); rx = stop_val;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk); rx = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    // Wait (bounded) for tsent, raise trecieve 3 cycles later, expect tsent to
    // fall one cycle after, drop trecieve 2 cycles after raising it.
    task automatic take_byte(input string tag, input logic [7:0] exp);
        logic       seen;
        logic       drop_ok;
        logic       stable;
        logic [7:0] got;
        seen = 1'b0; drop_ok = 1'b0; stable = 1'b0; got = 8'h00;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (bus_if.tsent) seen = 1'b1;
        end
        if (seen) begin
            got = t_byte();
            repeat (3) @(negedge clk);
            bus_if.trecieve = 1'b1;
            @(negedge clk);
            drop_ok = !bus_if.tsent;
            stable  = (t_byte() == got);
            @(negedge clk);
            bus_if.trecieve = 1'b0;
            @(negedge clk);
            exp_count++;
        end
        check_val({tag, "_seen"}, seen, 1'b1);
        check_val({tag, "_byte"}, got, exp);
        check_val({tag, "_tsent_drop"}, drop_ok, 1'b1);
        check_val({tag, "_t_stable"}, stable, 1'b1);
    endtask

    task automatic quiet(input int n, output logic saw);
        saw = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus_if.tsent) saw = 1'b1;
        end
    endtask

    initial begin
        logic saw;
        reset = 1'b0; rx = 1'b1; enable = 1'b1; clear_err = 1'b0;
        bus_if.trecieve = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check_val("rst_tsent", bus_if.tsent, 1'b0);
        check_val("rst_t", t_byte(), 8'h00);
        check_val("rst_count", byte_count, 8'd0);
        check_val("rst_errs", {framing_err, overrun_err}, 2'b00);
        check_val("rst_busy", busy, 1'b0);
        reset = 1'b1;
        idle(4);

        // ---- 1: single byte 0xA5 ----
        fork
            send_frame(8'hA5, 1'b1);
            take_byte("a5", 8'hA5);
        join
        check_val("a5_count", byte_count, exp_count);
        check_val("a5_errs", {framing_err, overrun_err}, 2'b00);

        // ---- 2: framing error on 0x3C, then 0x5A ----
        fork
            begin
                send_frame(8'h3C, 1'b0);
                idle(4);
                send_frame(8'h5A, 1'b1);
            end
            take_byte("frm_5a", 8'h5A);
        join
        check_val("frm_flag", framing_err, 1'b1);
        check_val("frm_count", byte_count, exp_count);
        check_val("frm_no_ovr", overrun_err, 1'b0);
        @(negedge clk); clear_err = 1'b1;
        @(negedge clk); clear_err = 1'b0;
        check_val("frm_cleared", framing_err, 1'b0);

        // ---- 3: overrun, 0x11/0x22/0x33 with no acknowledge ----
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        repeat (4) @(negedge clk);
        check_val("ovr_tsent", bus_if.tsent, 1'b1);
        check_val("ovr_held", t_byte(), 8'h11);
        check_val("ovr_flag", overrun_err, 1'b1);
        take_byte("ovr_11", 8'h11);
        take_byte("ovr_22", 8'h22);
        quiet(60, saw);
        check_val("ovr_33_dropped", saw, 1'b0);
        check_val("ovr_count", byte_count, exp_count);
        @(negedge clk); clear_err = 1'b1;
        @(negedge clk); clear_err = 1'b0;
        check_val("ovr_cleared", overrun_err, 1'b0);

        // ---- 4: pop and push in the same cycle ----
        // 0x44 sits in the output register, 0x66 in hold. The one-cycle ack
        // of 0x44 lands H_IDLE on the stop-sample edge of 0x77.
        send_frame(8'h44, 1'b1);
        send_frame(8'h66, 1'b1);
        repeat (4) @(negedge clk);
        check_val("pp_pre_t", t_byte(), 8'h44);
        fork
            send_frame(8'h77, 1'b1);
            begin
                @(negedge clk);
                repeat (76) @(negedge clk);
                bus_if.trecieve = 1'b1;
                @(negedge clk);
                bus_if.trecieve = 1'b0;
                exp_count++;
            end
        join
        take_byte("pp_66", 8'h66);
        take_byte("pp_77", 8'h77);
        check_val("pp_no_ovr", overrun_err, 1'b0);
        check_val("pp_count", byte_count, exp_count);

        // ---- 5: 3-cycle glitch on rx ----
        begin
            logic saw_busy;
            saw_busy = 1'b0;
            saw = 1'b0;
            @(negedge clk); rx = 1'b0;
            for (int i = 0; i < 24; i++) begin
                @(negedge clk);
                if (i == 2) rx = 1'b1;
                if (busy) saw_busy = 1'b1;
                if (bus_if.tsent) saw = 1'b1;
            end
            check_val("gl_busy_pulse", saw_busy, 1'b1);
            check_val("gl_busy_end", busy, 1'b0);
            check_val("gl_no_byte", saw, 1'b0);
            check_val("gl_no_err", {framing_err, overrun_err}, 2'b00);
        end

        // ---- 6a: asynchronous reset in the middle of R_DATA ----
        send_frame(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        check_val("ar_pre_tsent", bus_if.tsent, 1'b1);
        fork
            send_frame(8'h0F, 1'b1);
            begin
                repeat (30) @(negedge clk);
                check_val("ar_pre_busy", busy, 1'b1);
                #2 reset = 1'b0;
                #1;
                check_val("ar_tsent", bus_if.tsent, 1'b0);
                check_val("ar_t", t_byte(), 8'h00);
                check_val("ar_count", byte_count, 8'd0);
                check_val("ar_busy", busy, 1'b0);
            end
        join
        exp_count = 0;
        idle(4);
        reset = 1'b1;
        quiet(20, saw);
        check_val("ar_quiet", saw, 1'b0);

        // ---- 6b: enable drop mid-frame with a byte outstanding ----
        send_frame(8'h99, 1'b1);
        repeat (4) @(negedge clk);
        check_val("en_pre_tsent", bus_if.tsent, 1'b1);
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (40) @(negedge clk);
                enable = 1'b0;
                @(negedge clk);
                check_val("en_busy_off", busy, 1'b0);
                take_byte("en_99", 8'h99);
            end
        join
        repeat (4) @(negedge clk);
        enable = 1'b1;
        quiet(100, saw);
        check_val("en_partial_gone", saw, 1'b0);
        check_val("en_count", byte_count, exp_count);
        check_val("en_no_err", {framing_err, overrun_err}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
